// File: rtl/quad_operand_collector_pkg.sv
// Shared types for the quad operand collector.
// Slot index width matches the get_index result width.
package quad_operand_collector_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned NSLOT = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef logic [1:0] slot_t;

  localparam slot_t LAST_IDX = slot_t'(NSLOT - 1);

endpackage

// File: rtl/quad_operand_collector.sv
// Packs a serial operand stream into four slots A..D for get_index.
// Short groups end on in_last; unfilled slots get PAD and a clear mask bit.
module quad_operand_collector
  import quad_operand_collector_pkg::*;
#(
  parameter int unsigned  W   = OP_W,
  parameter logic [W-1:0] PAD = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic [3:0]   valid_mask
);

  state_e                     state_q, state_d;
  slot_t                      idx_q, idx_d;
  logic [NSLOT-1:0]           mask_q, mask_d;
  logic [NSLOT-1:0][W-1:0]    data_q, data_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    data_d  = data_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          data_d[idx_q] = in_data;
          mask_d[idx_q] = 1'b1;
          if (idx_q == LAST_IDX || in_last) begin
            // pad every slot above the closing operand
            for (int i = 0; i < NSLOT; i++) begin
              if (i > int'(idx_q)) data_d[i] = PAD;
            end
            state_d = HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + slot_t'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          mask_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == HOLD);
  assign A          = data_q[0];
  assign B          = data_q[1];
  assign C          = data_q[2];
  assign D          = data_q[3];
  assign valid_mask = mask_q;

endmodule

// File: tb/tb_quad_operand_collector.sv
// Scoreboard bench: stimulus queues expected groups, monitor checks them.
// Direct checks cover reset, HOLD stability, spacing and reset discard.
module tb_quad_operand_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] A, B, C, D;
  logic [3:0] valid_mask;

  quad_operand_collector dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .valid_mask (valid_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a, b, c, d;
    logic [3:0] m;
    int         rise;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   acc_cyc;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int a, input int b, input int c, input int d,
                      input int m);
    exp_t e;
    e.a = 3'(a); e.b = 3'(b); e.c = 3'(c); e.d = 3'(d);
    e.m = 4'(m);
    e.rise = acc_cyc;
    sbq.push_back(e);
  endtask

  // Monitor: checks rise timing, contents at handshake, mask shape.
  always @(negedge clk) begin
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        chk("mask_contig",
            int'(valid_mask == 4'b0001 || valid_mask == 4'b0011 ||
                 valid_mask == 4'b0111 || valid_mask == 4'b1111), 1);
      end
      if (out_valid && !ov_prev) begin
        if (sbq.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("rise_cycle", cyc, sbq[0].rise);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("handshake_without_expect", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("A", int'(A), int'(e.a));
          chk("B", int'(B), int'(e.b));
          chk("C", int'(C), int'(e.c));
          chk("D", int'(D), int'(e.d));
          chk("valid_mask", int'(valid_mask), int'(e.m));
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit last);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = 3'(d);
    in_last  = last;
    for (int k = 0; k < 20 && !done; k++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    if (!done) chk("send_timeout", 0, 1);
    acc_cyc = cyc;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_A"}, int'(A), 0);
    chk({name, "_B"}, int'(B), 0);
    chk({name, "_C"}, int'(C), 0);
    chk({name, "_D"}, int'(D), 0);
    chk({name, "_mask"}, int'(valid_mask), 0);
    chk({name, "_out_valid"}, int'(out_valid), 0);
    chk({name, "_in_ready"}, int'(in_ready), 1);
  endtask

  int acc1;

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk_zero("reset");

    // full group, consumer ready
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    push(1, 2, 3, 4, 4'b1111);
    idle();
    chk("t1_in_ready_hold", int'(in_ready), 0);
    tick();
    chk("t1_out_valid_after", int'(out_valid), 0);
    chk("t1_in_ready_after", int'(in_ready), 1);

    // short group padded
    send(7, 0); send(0, 1);
    push(7, 0, 0, 0, 4'b0011);
    idle();
    tick();
    tick();

    // held group ignores in_valid
    out_ready = 1'b0;
    send(2, 0); send(7, 0); send(5, 0); send(3, 0);
    push(2, 7, 5, 3, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 3'd6;
      chk("t3_in_ready", int'(in_ready), 0);
      chk("t3_out_valid", int'(out_valid), 1);
      chk("t3_hold_A", int'(A), 2);
      chk("t3_hold_B", int'(B), 7);
      chk("t3_hold_C", int'(C), 5);
      chk("t3_hold_D", int'(D), 3);
      tick();
    end
    idle();
    out_ready = 1'b1;
    tick();
    chk("t3_release_in_ready", int'(in_ready), 1);
    chk("t3_release_mask", int'(valid_mask), 0);
    chk("t3_release_A", int'(A), 2);
    tick();

    // back-to-back groups
    send(6, 0); send(6, 0); send(5, 0); send(5, 0);
    push(6, 6, 5, 5, 4'b1111);
    acc1 = acc_cyc;
    send(7, 0); send(7, 0); send(7, 0); send(3, 0);
    push(7, 7, 7, 3, 4'b1111);
    chk("t4_spacing", acc_cyc - acc1, 5);
    idle();
    tick();
    chk("t4_pulse_width", int'(out_valid), 0);
    tick();

    // reset discards partial group
    send(2, 0); send(1, 0);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("t5_reset");
    send(1, 0); send(6, 0); send(5, 0); send(6, 0);
    push(1, 6, 5, 6, 4'b1111);
    idle();
    tick();
    tick();

    // single operand, consumer stalled
    out_ready = 1'b0;
    send(7, 1);
    push(7, 0, 0, 0, 4'b0001);
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("t6_in_ready_stall", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t6_in_ready_release", int'(in_ready), 1);

    tick();
    tick();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
